regbank_writer: RTL and testbench
=================================

Name: regbank_writer

Overview:
- Write side of the CPU's 32x32 register bank.
- Decodes a 5-bit write address and stores 32-bit data into one of 32 registers.
- Exposes all 32 register values in parallel on Q0..Q31 for the 32-way read-select multiplexer.
- Includes a sequential clear sweep (one register per cycle, with a busy flag) and a write accept/drop handshake.

Parameters:
- R0_ZERO, 1, when 1 register 0 is hardwired to zero and writes to it have no effect; when 0 it is an ordinary register.
- RESET_VAL, 32'h0000_0000, value loaded into every register on rst (register 0 stays 0 when R0_ZERO=1).

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- we  input  1  write request, sampled each cycle.
- wa  input  5  write address 0..31.
- wd  input  32  write data.
- clr  input  1  start a clear sweep (single-cycle pulse or level; sampled only in IDLE).
- busy  output  1  high while a sweep is in progress.
- wack  output  1  one-cycle pulse: the write sampled on the previous edge was accepted.
- wdrop  output  1  one-cycle pulse: the write sampled on the previous edge was dropped.
- Q0..Q31  output  32 each  current register contents; Q[n] is register n.

Behaviour:
- Reset: on a rising edge with rst=1:
  - registers 1..31 take RESET_VAL; register 0 takes 0 if R0_ZERO=1, else RESET_VAL;
  - state goes to IDLE, sweep counter to 0;
  - busy=0, wack=0, wdrop=0.
  - rst overrides we and clr, and aborts a sweep in progress.
- States:
  - IDLE: clr=1 moves to SWEEP with counter=0. clr takes priority over a simultaneous we.
  - SWEEP: each edge writes 0 to register[counter] and increments the counter. The edge where counter=31 clears register 31 and returns to IDLE with counter=0.
  - busy is registered and equals (state==SWEEP). After a clr edge, busy is high for exactly 32 cycles.
  - clr sampled during SWEEP is ignored; the sweep is not restarted.
- Write acceptance: a write is accepted when we=1, the state is IDLE, and clr=0.
  - On acceptance, register[wa] takes wd on that edge; Q reflects the new value in the following cycle (1-cycle write latency, no combinational write-through).
  - wack=1 for the following cycle only.
- Write drop: we=1 while in SWEEP, or we=1 together with clr=1 in IDLE, is dropped.
  - No register changes; wdrop=1 for the following cycle.
  - wack and wdrop are never both 1.
- Register 0 with R0_ZERO=1: a write to wa=0 is accepted (wack pulses) but Q0 stays 0.
- Only one register changes per edge. The write decoder is a full 5-to-32 one-hot decode; no wrap-around or out-of-range addresses exist.
- No read ports: read selection is done externally on Q0..Q31.

Optional Feature:
- Macro: REGBANK_LASTWR_EN.
- Defined:
  - adds outputs last_wa (5 bits) and last_wd (32 bits), updated only on accepted writes (including wa=0) to the accepted address/data;
  - both reset to 0;
  - sweep writes do not update them.
- Not defined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
1. Reset then write: rst=1 for 2 cycles, release; we=1, wa=5, wd=32'hDEADBEEF for one cycle -> next cycle Q5=32'hDEADBEEF, wack=1, wdrop=0; all other Q = 0.
2. Register 0 (R0_ZERO=1): we=1, wa=0, wd=32'hFFFFFFFF -> wack=1 next cycle, Q0 stays 0. With R0_ZERO=0 -> Q0=32'hFFFFFFFF.
3. Sweep: fill registers 1..31 with value n+32'h100, pulse clr -> busy high exactly 32 cycles. Register k reads 0 from the cycle after sweep edge k; all Q = 0 when busy falls.
4. Write during sweep: we=1, wa=7, wd=32'h1234 on cycle 10 of the sweep -> wdrop=1 next cycle, wack=0, Q7 ends at 0. Repeat clr mid-sweep -> busy count still 32.
5. Simultaneous clr and we in IDLE: clr=1, we=1, wa=3, wd=32'hA5A5 -> wdrop=1, busy=1 next cycle, Q3 not written.
6. Reset mid-sweep: rst=1 on sweep cycle 15 -> next cycle busy=0, state IDLE, all registers = RESET_VAL (Q0=0). With REGBANK_LASTWR_EN defined -> last_wa=0, last_wd=0.

Source files
------------

// File: rtl/regbank_writer.sv
// Write side of the 32x32 register bank: one-hot write decode, clear sweep, accept/drop pulses.
// Optional REGBANK_LASTWR_EN adds last_wa/last_wd tracking of the most recent accepted write.
module regbank_writer #(
  parameter bit          R0_ZERO   = 1'b1,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic        clr,
  output logic        busy,
  output logic        wack,
  output logic        wdrop,
`ifdef REGBANK_LASTWR_EN
  output logic [4:0]  last_wa,
  output logic [31:0] last_wd,
`endif
  output logic [31:0] Q0,  output logic [31:0] Q1,  output logic [31:0] Q2,  output logic [31:0] Q3,
  output logic [31:0] Q4,  output logic [31:0] Q5,  output logic [31:0] Q6,  output logic [31:0] Q7,
  output logic [31:0] Q8,  output logic [31:0] Q9,  output logic [31:0] Q10, output logic [31:0] Q11,
  output logic [31:0] Q12, output logic [31:0] Q13, output logic [31:0] Q14, output logic [31:0] Q15,
  output logic [31:0] Q16, output logic [31:0] Q17, output logic [31:0] Q18, output logic [31:0] Q19,
  output logic [31:0] Q20, output logic [31:0] Q21, output logic [31:0] Q22, output logic [31:0] Q23,
  output logic [31:0] Q24, output logic [31:0] Q25, output logic [31:0] Q26, output logic [31:0] Q27,
  output logic [31:0] Q28, output logic [31:0] Q29, output logic [31:0] Q30, output logic [31:0] Q31
);

  typedef enum logic {IDLE, SWEEP} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        wack_q, wdrop_q;
  logic        accept, drop;
  logic [31:0] wsel, csel;
  logic [31:0] regs_q [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wack_q  <= 1'b0;
      wdrop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wack_q  <= accept;
      wdrop_q <= drop;
    end
  end

  // The counter wraps 31->0 on its own, so leaving SWEEP needs no explicit clear.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept = we && (state_q == IDLE) && !clr;
    drop   = we && !accept;
    busy   = (state_q == SWEEP);
    wack   = wack_q;
    wdrop  = wdrop_q;
    wsel   = '0;
    csel   = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      wsel[i] = accept && (wa == 5'(i));
      csel[i] = (state_q == SWEEP) && (cnt_q == 5'(i));
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 32; i++) begin
      if (rst)                   regs_q[i] <= (R0_ZERO && i == 0) ? '0 : RESET_VAL;
      else if (R0_ZERO && i == 0) regs_q[i] <= '0;
      else if (csel[i])          regs_q[i] <= '0;
      else if (wsel[i])          regs_q[i] <= wd;
    end
  end

`ifdef REGBANK_LASTWR_EN
  logic [4:0]  last_wa_q;
  logic [31:0] last_wd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_wa_q <= '0;
      last_wd_q <= '0;
    end else if (accept) begin
      last_wa_q <= wa;
      last_wd_q <= wd;
    end
  end

  assign last_wa = last_wa_q;
  assign last_wd = last_wd_q;
`endif

  assign Q0  = regs_q[0];  assign Q1  = regs_q[1];  assign Q2  = regs_q[2];  assign Q3  = regs_q[3];
  assign Q4  = regs_q[4];  assign Q5  = regs_q[5];  assign Q6  = regs_q[6];  assign Q7  = regs_q[7];
  assign Q8  = regs_q[8];  assign Q9  = regs_q[9];  assign Q10 = regs_q[10]; assign Q11 = regs_q[11];
  assign Q12 = regs_q[12]; assign Q13 = regs_q[13]; assign Q14 = regs_q[14]; assign Q15 = regs_q[15];
  assign Q16 = regs_q[16]; assign Q17 = regs_q[17]; assign Q18 = regs_q[18]; assign Q19 = regs_q[19];
  assign Q20 = regs_q[20]; assign Q21 = regs_q[21]; assign Q22 = regs_q[22]; assign Q23 = regs_q[23];
  assign Q24 = regs_q[24]; assign Q25 = regs_q[25]; assign Q26 = regs_q[26]; assign Q27 = regs_q[27];
  assign Q28 = regs_q[28]; assign Q29 = regs_q[29]; assign Q30 = regs_q[30]; assign Q31 = regs_q[31];

endmodule

// File: tb/tb_regbank_writer.sv
// Bench for regbank_writer: two instances (R0 hardwired / R0 ordinary with nonzero reset value)
// driven identically and checked every cycle against a bank-level model.
module tb_regbank_writer;

  localparam logic [31:0] RVB = 32'h5A5A_0F0F;

  logic        clk = 1'b0;
  logic        rst, we, clr;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        busy_a, wack_a, wdrop_a, busy_b, wack_b, wdrop_b;
  logic [31:0] qa [32];
  logic [31:0] qb [32];
`ifdef REGBANK_LASTWR_EN
  logic [4:0]  lwa_a, lwa_b;
  logic [31:0] lwd_a, lwd_b;
`endif

  always #5 clk = ~clk;

  regbank_writer #(.R0_ZERO(1'b1), .RESET_VAL(32'h0000_0000)) dut_a (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .clr(clr),
    .busy(busy_a), .wack(wack_a), .wdrop(wdrop_a),
`ifdef REGBANK_LASTWR_EN
    .last_wa(lwa_a), .last_wd(lwd_a),
`endif
    .Q0(qa[0]),   .Q1(qa[1]),   .Q2(qa[2]),   .Q3(qa[3]),   .Q4(qa[4]),   .Q5(qa[5]),   .Q6(qa[6]),   .Q7(qa[7]),
    .Q8(qa[8]),   .Q9(qa[9]),   .Q10(qa[10]), .Q11(qa[11]), .Q12(qa[12]), .Q13(qa[13]), .Q14(qa[14]), .Q15(qa[15]),
    .Q16(qa[16]), .Q17(qa[17]), .Q18(qa[18]), .Q19(qa[19]), .Q20(qa[20]), .Q21(qa[21]), .Q22(qa[22]), .Q23(qa[23]),
    .Q24(qa[24]), .Q25(qa[25]), .Q26(qa[26]), .Q27(qa[27]), .Q28(qa[28]), .Q29(qa[29]), .Q30(qa[30]), .Q31(qa[31])
  );

  regbank_writer #(.R0_ZERO(1'b0), .RESET_VAL(RVB)) dut_b (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .clr(clr),
    .busy(busy_b), .wack(wack_b), .wdrop(wdrop_b),
`ifdef REGBANK_LASTWR_EN
    .last_wa(lwa_b), .last_wd(lwd_b),
`endif
    .Q0(qb[0]),   .Q1(qb[1]),   .Q2(qb[2]),   .Q3(qb[3]),   .Q4(qb[4]),   .Q5(qb[5]),   .Q6(qb[6]),   .Q7(qb[7]),
    .Q8(qb[8]),   .Q9(qb[9]),   .Q10(qb[10]), .Q11(qb[11]), .Q12(qb[12]), .Q13(qb[13]), .Q14(qb[14]), .Q15(qb[15]),
    .Q16(qb[16]), .Q17(qb[17]), .Q18(qb[18]), .Q19(qb[19]), .Q20(qb[20]), .Q21(qb[21]), .Q22(qb[22]), .Q23(qb[23]),
    .Q24(qb[24]), .Q25(qb[25]), .Q26(qb[26]), .Q27(qb[27]), .Q28(qb[28]), .Q29(qb[29]), .Q30(qb[30]), .Q31(qb[31])
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] actual=%h required=%h", nm, idx, act, exp);
    end
  endtask

  // Bank model: sweep_idx is the next register to clear, -1 when no sweep is running.
  logic [31:0] ma [32];
  logic [31:0] mb [32];
  int          sweep_idx = -1;
  bit          m_wack = 1'b0, m_wdrop = 1'b0, armed = 1'b0;
  logic [4:0]  m_lwa = '0;
  logic [31:0] m_lwd = '0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        ma[i] = 32'h0;
        mb[i] = RVB;
      end
      sweep_idx = -1;
      m_wack = 1'b0; m_wdrop = 1'b0;
      m_lwa = '0; m_lwd = '0;
      armed = 1'b1;
    end else if (sweep_idx >= 0) begin
      m_wack = 1'b0;
      m_wdrop = we;
      ma[sweep_idx] = 32'h0;
      mb[sweep_idx] = 32'h0;
      sweep_idx = (sweep_idx == 31) ? -1 : sweep_idx + 1;
    end else if (clr) begin
      sweep_idx = 0;
      m_wack = 1'b0;
      m_wdrop = we;
    end else begin
      m_wack = we;
      m_wdrop = 1'b0;
      if (we) begin
        if (wa != 5'd0) ma[wa] = wd;
        mb[wa] = wd;
        m_lwa = wa;
        m_lwd = wd;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("busy_a", 0, busy_a, sweep_idx >= 0);
      chk("busy_b", 0, busy_b, sweep_idx >= 0);
      chk("wack_a", 0, wack_a, m_wack);
      chk("wack_b", 0, wack_b, m_wack);
      chk("wdrop_a", 0, wdrop_a, m_wdrop);
      chk("wdrop_b", 0, wdrop_b, m_wdrop);
      for (int i = 0; i < 32; i++) begin
        chk("qa", i, qa[i], ma[i]);
        chk("qb", i, qb[i], mb[i]);
      end
`ifdef REGBANK_LASTWR_EN
      chk("last_wa_a", 0, lwa_a, m_lwa);
      chk("last_wd_a", 0, lwd_a, m_lwd);
      chk("last_wa_b", 0, lwa_b, m_lwa);
      chk("last_wd_b", 0, lwd_b, m_lwd);
`endif
    end
  end

  initial begin
    int bc;
    bit done;
    rst = 1'b1; we = 1'b0; clr = 1'b0; wa = '0; wd = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 0, busy_a, 1'b0);
    chk("rst_q0_b", 0, qb[0], RVB);
    chk("rst_q9_a", 9, qa[9], 32'h0);

    // Plain write
    we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF;
    @(negedge clk);
    we = 1'b0;
    chk("t1_q5", 5, qa[5], 32'hDEAD_BEEF);
    chk("t1_wack", 0, wack_a, 1'b1);
    chk("t1_wdrop", 0, wdrop_a, 1'b0);
    chk("t1_q6", 6, qa[6], 32'h0);

    // Register 0 behaviour in both configurations
    we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF;
    @(negedge clk);
    we = 1'b0;
    chk("t2_wack", 0, wack_a, 1'b1);
    chk("t2_q0_a", 0, qa[0], 32'h0);
    chk("t2_q0_b", 0, qb[0], 32'hFFFF_FFFF);

    for (int n = 1; n < 32; n++) begin
      we = 1'b1; wa = 5'(n); wd = 32'(n) + 32'h100;
      @(negedge clk);
    end
    we = 1'b0;
    chk("fill_q31", 31, qa[31], 32'h11F);

    // Sweep with a write on sweep cycle 10 and a repeated clr on cycle 6
    clr = 1'b1;
    bc = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      clr = (c == 5);
      we  = (c == 9);
      wa  = 5'd7; wd = 32'h1234;
      if (c == 10) chk("t4_wdrop", 0, wdrop_a, 1'b1);
      if (c == 10) chk("t4_wack", 0, wack_a, 1'b0);
      if (busy_a) bc++;
      else done = 1'b1;
    end
    clr = 1'b0; we = 1'b0;
    chk("t3_busy_cycles", 0, bc, 32);
    chk("t4_q7", 7, qa[7], 32'h0);
    chk("t3_q31_b", 31, qb[31], 32'h0);

    // clr together with we, then reset on sweep cycle 15
    clr = 1'b1; we = 1'b1; wa = 5'd3; wd = 32'hA5A5;
    @(negedge clk);
    clr = 1'b0; we = 1'b0;
    chk("t5_wdrop", 0, wdrop_a, 1'b1);
    chk("t5_busy", 0, busy_a, 1'b1);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_busy", 0, busy_a, 1'b0);
    chk("t6_q0_a", 0, qa[0], 32'h0);
    chk("t6_q3_b", 3, qb[3], RVB);
    chk("t6_q0_b", 0, qb[0], RVB);
`ifdef REGBANK_LASTWR_EN
    chk("t6_last_wa", 0, lwa_a, 5'd0);
    chk("t6_last_wd", 0, lwd_a, 32'h0);
`endif

    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      clr = ($urandom_range(0, 39) == 0);
      we  = ($urandom_range(0, 2) != 0);
      wa  = 5'($urandom_range(0, 31));
      wd  = $urandom;
      @(negedge clk);
    end
    rst = 1'b0; clr = 1'b0; we = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
